// File: rtl/lut_stream_pkg.sv
// Shared constants and types for the runtime-programmable LUT stream engine.
// Default geometry (IN_W=3, OUT_W=4, DEPTH=4) and the transfer-counter width.
package lut_stream_pkg;

  localparam int IN_W_DEF  = 3;
  localparam int OUT_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W     = 16;

  typedef logic [OUT_W_DEF-1:0] out_code_t;

endpackage

// File: rtl/lut_stream_if.sv
// Stream and configuration bundle for lut_stream_engine.
// The master side drives codes and table writes; the slave side is the engine.
interface lut_stream_if
  import lut_stream_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic             cfg_we;
  logic [IN_W-1:0]  cfg_addr;
  logic [OUT_W-1:0] cfg_data;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lut_stream_fifo.sv
// Synchronous FIFO with registered occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module lut_stream_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_BITS'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: storage is reset so the head reads 0 out of reset; with only a few
  // entries that is cheaper than gating the output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // NOTE: non-blocking assignments keep every flop updating from pre-edge
  // values, so the pointer and count logic cannot race each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lut_stream_engine.sv
// Runtime-programmable truth-table engine: table + registered lookup stage + output FIFO.
// Define LUT_CNT_EN to add the 16-bit completed-transfer counter port xfer_cnt.
module lut_stream_engine
  import lut_stream_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  lut_stream_if.slave      bus
`ifdef LUT_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  localparam int ENTRIES = 2 ** IN_W;

  logic [OUT_W-1:0] r_table [ENTRIES];
  logic             r_s1_valid;
  logic [OUT_W-1:0] r_s1_data;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [OUT_W-1:0] w_fifo_head;

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = !r_s1_valid || !w_fifo_full;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_push        = r_s1_valid && !w_fifo_full;
  assign w_pop         = !w_fifo_empty && bus.out_ready;
  assign bus.out_valid = !w_fifo_empty;
  assign bus.out_data  = w_fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= '0;
    end else if (bus.cfg_we) begin
      r_table[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // The lookup reads the pre-edge table, so a same-edge write to the same
  // entry only affects later inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= r_table[bus.in_data];
    end else if (w_push) begin
      r_s1_valid <= 1'b0;
    end
  end

  lut_stream_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_s1_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

`ifdef LUT_CNT_EN
  logic [CNT_W-1:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_xfer_cnt <= '0;
    else if (w_pop) r_xfer_cnt <= r_xfer_cnt + 1'b1;
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_lut_stream_engine.sv
// Directed bench for lut_stream_engine: default geometry plus a 1-bit/DEPTH=2 instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lut_stream_engine;
  import lut_stream_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  out_code_t got_q[$];

  always #5 clk = ~clk;

  lut_stream_if #(.IN_W(3), .OUT_W(4)) bus ();
  lut_stream_if #(.IN_W(1), .OUT_W(1)) bus_s ();

`ifdef LUT_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] xfer_cnt_s;
`endif

  lut_stream_engine #(.IN_W(3), .OUT_W(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LUT_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  lut_stream_engine #(.IN_W(1), .OUT_W(1), .DEPTH(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
`ifdef LUT_CNT_EN
    ,
    .xfer_cnt (xfer_cnt_s)
`endif
  );

  task automatic cfg_write(input logic [2:0] addr, input logic [3:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Pops with out_ready=1 until n more codes are captured or the budget runs out.
  task automatic drain(input int n, input int budget);
    int target;
    target = got_q.size() + n;
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && got_q.size() < target; c++) begin
      if (bus.out_valid) got_q.push_back(bus.out_data);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
  endtask

  task automatic test_stream();
    out_code_t exp [8];
    int sent, got, cyc, acc_cyc, val_cyc, last_pop;
    logic acc;
    exp = '{4'b0001, 4'b1001, 4'b1001, 4'b0110, 4'b0001, 4'b0010, 4'b0000, 4'b0110};
    for (int i = 0; i < 8; i++) cfg_write(3'(i), exp[i]);
    sent = 0; got = 0; cyc = 0; acc_cyc = -1; val_cyc = -1; last_pop = -1;
    bus.out_ready = 1'b1;
    while (got < 8 && cyc < 40) begin
      bus.in_valid = (sent < 8);
      bus.in_data  = 3'(sent);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (val_cyc < 0) val_cyc = cyc;
        last_pop = cyc;
        n_checks++;
        if (bus.out_data !== exp[got]) begin
          n_fail++; $display("FAIL stream_out[%0d]: got %b want %b", got, bus.out_data, exp[got]);
        end
        got++;
      end
      @(negedge clk);
      if (acc) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        sent++;
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", got); end
    n_checks++; if (val_cyc != acc_cyc + 2) begin n_fail++; $display("FAIL stream_latency: first valid seen %0d cycles after accept edge, want 2", val_cyc - acc_cyc); end
    n_checks++; if (last_pop - val_cyc != 7) begin n_fail++; $display("FAIL stream_throughput: 8 pops spanned %0d cycles, want 7", last_pop - val_cyc + 1 - 1); end
  endtask

  task automatic test_backpressure();
    out_code_t exp [5];
    int acc_n;
    exp = '{4'b0001, 4'b1001, 4'b1001, 4'b0110, 4'b0001};
    acc_n = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 3'(acc_n);
      if (bus.in_ready) acc_n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (acc_n != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", acc_n); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready); end
    got_q.delete();
    bus.out_ready = 1'b1;
    if (bus.out_valid) got_q.push_back(bus.out_data);
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after_pop: got %b want 1", bus.in_ready); end
    drain(4, 20);
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %b want %b", i, (i < got_q.size()) ? got_q[i] : 4'bx, exp[i]);
      end
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty_after: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_same_edge();
    bus.in_valid = 1'b1;
    bus.in_data  = 3'd5;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd5;
    bus.cfg_data = 4'b1111;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL same_edge_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.cfg_we = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    got_q.delete();
    drain(2, 20);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL same_edge_count: got %0d want 2", got_q.size()); end
    n_checks++; if (got_q.size() < 1 || got_q[0] !== 4'b0010) begin n_fail++; $display("FAIL same_edge_old: got %b want 0010", (got_q.size() > 0) ? got_q[0] : 4'bx); end
    n_checks++; if (got_q.size() < 2 || got_q[1] !== 4'b1111) begin n_fail++; $display("FAIL same_edge_new: got %b want 1111", (got_q.size() > 1) ? got_q[1] : 4'bx); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 3'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL mid_out_data: got %h want 0", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 3'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    got_q.delete();
    drain(1, 10);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 4'b0000) begin n_fail++; $display("FAIL mid_cleared_table: got %b want 0000 (%0d items)", (got_q.size() > 0) ? got_q[0] : 4'bx, got_q.size()); end
  endtask

  task automatic test_small();
    logic ins [4];
    logic exp [4];
    int sent, got;
    logic acc;
    ins = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus_s.cfg_we = 1'b1; bus_s.cfg_addr = 1'b0; bus_s.cfg_data = 1'b1;
    @(negedge clk);
    bus_s.cfg_addr = 1'b1; bus_s.cfg_data = 1'b0;
    @(negedge clk);
    bus_s.cfg_we = 1'b0;
    sent = 0; got = 0;
    for (int c = 0; c < 200 && got < 4; c++) begin
      bus_s.in_valid  = (sent < 4);
      bus_s.in_data   = ins[(sent < 4) ? sent : 0];
      bus_s.out_ready = 1'($urandom_range(0, 1));
      acc = bus_s.in_valid && bus_s.in_ready;
      if (bus_s.out_valid && bus_s.out_ready) begin
        n_checks++;
        if (bus_s.out_data !== exp[got]) begin
          n_fail++; $display("FAIL small_out[%0d]: got %b want %b", got, bus_s.out_data, exp[got]);
        end
        got++;
      end
      @(negedge clk);
      if (acc) sent++;
    end
    bus_s.in_valid  = 1'b0;
    bus_s.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL small_count: got %0d want 4", got); end
    n_checks++; if (bus_s.out_valid !== 1'b0) begin n_fail++; $display("FAIL small_no_dup: out_valid %b want 0", bus_s.out_valid); end
    bus_s.out_ready = 1'b0;
  endtask

`ifdef LUT_CNT_EN
  task automatic test_counter();
    int sent, pops;
    logic acc;
    pulse_reset();
    n_checks++; if (xfer_cnt !== 16'd0 || xfer_cnt_s !== 16'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d/%0d want 0/0", xfer_cnt, xfer_cnt_s); end
    sent = 0; pops = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 70100 && pops < 70000; c++) begin
      bus.in_valid = (sent < 70000);
      bus.in_data  = 3'(sent);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) pops++;
      @(negedge clk);
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (xfer_cnt !== 16'd4464) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 4464", xfer_cnt); end
    bus.in_valid = 1'b1;
    bus.in_data  = 3'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL cnt_stall_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (xfer_cnt !== 16'd4464) begin n_fail++; $display("FAIL cnt_stall_hold: got %0d want 4464", xfer_cnt); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++; if (xfer_cnt !== 16'd4465) begin n_fail++; $display("FAIL cnt_step: got %0d want 4465", xfer_cnt); end
  endtask
`endif

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus_s.cfg_we = 1'b0; bus_s.cfg_addr = '0; bus_s.cfg_data = '0;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_same_edge();
    test_reset_mid();
    test_small();
`ifdef LUT_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
